// File: rtl/apb_rr_master.sv
// Multi-requester APB master: round-robin arbitration, IDLE/SETUP/ACCESS sequencing,
// registered outputs, and a timeout that aborts stalled ACCESS phases with an error.
module apb_rr_master #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    output logic               PWRITE,
    output logic               PSELx,
    output logic               PENABLE,
    input  logic               PREADY,
    input  logic [DW-1:0]      PRDATA,
    input  logic               PSLVERR
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic            pwrite_q, pwrite_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            tmo;

    // Scan last+1, last+2, ... so the most recent owner has the lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IW'((int'(last_q) + k) % int'(NREQ));
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign tmo = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        ack_d     = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = NREQ'(1) << pick;
                    last_d    = pick;
                    paddr_d   = req_addr[int'(pick)*AW +: AW];
                    pwdata_d  = req_wdata[int'(pick)*DW +: DW];
                    pwrite_d  = req_write[pick];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY || tmo) begin
                    ack_d     = grant_q;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    grant_d   = '0;
                    state_d   = IDLE;
                    if (PREADY) begin
                        err_d = PSLVERR;
                        if (!pwrite_q) begin
                            rdata_d = PRDATA;
                        end
                    end else begin
                        // Timed-out reads return zero rather than stale bus data.
                        err_d = 1'b1;
                        if (!pwrite_q) begin
                            rdata_d = '0;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                grant_d   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    assign grant   = grant_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PSELx   = psel_q;
    assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin model.
module tb_apb_rr_master;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 4;

    logic               PCLK;
    logic               PRESETn;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               err;
    logic [AW-1:0]      PADDR;
    logic [DW-1:0]      PWDATA;
    logic               PWRITE;
    logic               PSELx;
    logic               PENABLE;
    logic               PREADY;
    logic [DW-1:0]      PRDATA;
    logic               PSLVERR;

    int tests;
    int fails;
    int mlast;
    logic [DW-1:0] mrdata;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .ack(ack),
        .rdata(rdata), .err(err), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSELx(PSELx), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Round-robin rule: first requesting index after the last owner, modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int lst);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        PRESETn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        repeat (3) tick();
        tests++;
        if ({grant, ack, rdata, err, PADDR, PWDATA, PWRITE, PSELx, PENABLE} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got grant=%b ack=%b psel=%b paddr=%h, expected all 0",
                     grant, ack, PSELx, PADDR);
        end
        PRESETn = 1'b1;
        mlast = NREQ - 1;
        mrdata = '0;
        tick();
    endtask

    task automatic test_single_read();
        req = 4'b0001; req_write = 4'b0000; req_addr[0 +: AW] = 32'h10;
        PREADY = 1'b1; PRDATA = 32'd16;
        tick();
        tests++;
        if (PSELx !== 1'b1 || PENABLE !== 1'b0 || grant !== 4'b0001 || PADDR !== 32'h10) begin
            fails++;
            $display("FAIL read_setup: got psel=%b pen=%b grant=%b paddr=%h, expected 1 0 0001 10",
                     PSELx, PENABLE, grant, PADDR);
        end
        tick();
        tests++;
        if (PENABLE !== 1'b1 || ack !== 4'b0000) begin
            fails++;
            $display("FAIL read_access: got pen=%b ack=%b, expected 1 0000", PENABLE, ack);
        end
        tick();
        req = '0;
        tests++;
        if (ack !== 4'b0001 || rdata !== 32'd16 || err !== 1'b0 ||
            {PSELx, PENABLE, grant} !== '0) begin
            fails++;
            $display("FAIL read_done: got ack=%b rdata=%0d err=%b psel=%b, expected 0001 16 0 0",
                     ack, rdata, err, PSELx);
        end
        tick();
        tests++;
        if (ack !== 4'b0000 || err !== 1'b0) begin
            fails++;
            $display("FAIL ack_pulse: got ack=%b err=%b, expected 0000 0", ack, err);
        end
        mlast = 0;
        mrdata = 32'd16;
    endtask

    task automatic test_write_wait();
        req = 4'b0100; req_write = 4'b0100;
        req_addr[2*AW +: AW] = 32'h20; req_wdata[2*DW +: DW] = 32'hA5;
        PREADY = 1'b0;
        tick();
        req_addr[2*AW +: AW] = 32'hDEAD; req_wdata[2*DW +: DW] = 32'hBEEF; req_write = 4'b0;
        tests++;
        if (grant !== 4'b0100 || PWRITE !== 1'b1 || PADDR !== 32'h20 || PWDATA !== 32'hA5) begin
            fails++;
            $display("FAIL write_setup: got grant=%b pwrite=%b paddr=%h pwdata=%h", grant, PWRITE,
                     PADDR, PWDATA);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (ack !== 4'b0 || PENABLE !== 1'b1 || PADDR !== 32'h20 || PWDATA !== 32'hA5 ||
                PWRITE !== 1'b1) begin
                fails++;
                $display("FAIL write_wait%0d: got ack=%b pen=%b paddr=%h pwdata=%h", i, ack,
                         PENABLE, PADDR, PWDATA);
            end
        end
        PREADY = 1'b1;
        tick();
        req = '0;
        tests++;
        if (ack !== 4'b0100 || err !== 1'b0 || rdata !== mrdata || PSELx !== 1'b0) begin
            fails++;
            $display("FAIL write_done: got ack=%b err=%b rdata=%h, expected 0100 0 %h", ack, err,
                     rdata, mrdata);
        end
        mlast = 2;
        tick();
    endtask

    task automatic test_round_robin();
        int exp;
        req = 4'b1111; req_write = 4'b0000; PREADY = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp = rr_pick(req, mlast);
            PRDATA = 32'h100 + n;
            tick();
            tests++;
            if (grant !== 4'(1 << exp) || PSELx !== 1'b1) begin
                fails++;
                $display("FAIL rr_grant%0d: got %b, expected %b", n, grant, 4'(1 << exp));
            end
            tick();
            tick();
            tests++;
            if (ack !== 4'(1 << exp) || rdata !== 32'h100 + n || PSELx !== 1'b0) begin
                fails++;
                $display("FAIL rr_ack%0d: got ack=%b rdata=%h, expected %b %h", n, ack, rdata,
                         4'(1 << exp), 32'h100 + n);
            end
            mlast = exp;
            mrdata = 32'h100 + n;
        end
        req = '0;
        tick();
    endtask

    task automatic test_priority_rotation();
        logic [NREQ-1:0] exp_g [2];
        exp_g[0] = 4'b1000; exp_g[1] = 4'b0001;
        req = 4'b0010; req_write = 4'b1111; PREADY = 1'b1;
        repeat (3) tick();
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            tick();
            tests++;
            if (grant !== exp_g[n]) begin
                fails++;
                $display("FAIL prio_grant%0d: got %b, expected %b", n, grant, exp_g[n]);
            end
            tick();
            tick();
            req = req & ~exp_g[n];
        end
        mlast = 0;
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        req = 4'b0010; req_write = 4'b0000; PREADY = 1'b0; PRDATA = 32'hFFFF;
        tick();
        tick();
        for (int i = 1; i <= TMO; i++) begin
            tick();
            if (i < TMO) begin
                tests++;
                if (ack !== 4'b0 || PSELx !== 1'b1) begin
                    fails++;
                    $display("FAIL tmo_wait%0d: got ack=%b psel=%b, expected 0000 1", i, ack, PSELx);
                end
            end
        end
        req = '0;
        tests++;
        if (ack !== 4'b0010 || err !== 1'b1 || rdata !== 32'h0 || PSELx !== 1'b0) begin
            fails++;
            $display("FAIL tmo_done: got ack=%b err=%b rdata=%h psel=%b, expected 0010 1 0 0", ack,
                     err, rdata, PSELx);
        end
        tick();
        tests++;
        if ({PSELx, PENABLE, grant, ack, err} !== '0) begin
            fails++;
            $display("FAIL tmo_idle: got psel=%b grant=%b ack=%b, expected 0", PSELx, grant, ack);
        end
        mlast = 1;
        mrdata = '0;
    endtask

    task automatic test_slave_error();
        req = 4'b0001; req_write = 4'b0001; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h55;
        repeat (3) tick();
        req = '0;
        tests++;
        if (ack !== 4'b0001 || err !== 1'b1 || rdata !== mrdata) begin
            fails++;
            $display("FAIL slverr: got ack=%b err=%b rdata=%h, expected 0001 1 %h", ack, err, rdata,
                     mrdata);
        end
        PSLVERR = 1'b0;
        mlast = 0;
        tick();
    endtask

    task automatic test_reset_abort();
        req = 4'b0100; req_write = 4'b0000; PREADY = 1'b0;
        tick();
        tick();
        PRESETn = 1'b0;
        #1;
        tests++;
        if ({PSELx, PENABLE, grant, ack} !== '0) begin
            fails++;
            $display("FAIL rst_abort: got psel=%b pen=%b grant=%b ack=%b, expected 0", PSELx,
                     PENABLE, grant, ack);
        end
        tick();
        PRESETn = 1'b1;
        mlast = NREQ - 1;
        mrdata = '0;
        req = 4'b1111; PREADY = 1'b1; PRDATA = 32'h77;
        tick();
        tests++;
        if (grant !== 4'b0001 || ack !== 4'b0) begin
            fails++;
            $display("FAIL rst_regrant: got grant=%b ack=%b, expected 0001 0000", grant, ack);
        end
        req = '0;
        tick();
        tick();
        tests++;
        if (ack !== 4'b0001 || rdata !== 32'h77) begin
            fails++;
            $display("FAIL rst_after: got ack=%b rdata=%h, expected 0001 77", ack, rdata);
        end
        mlast = 0;
        mrdata = 32'h77;
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pending;
        logic [AW-1:0] m_addr [NREQ];
        logic [DW-1:0] m_wdata [NREQ];
        logic m_write [NREQ];
        logic [AW-1:0] l_addr;
        logic [DW-1:0] l_wdata;
        logic l_write;
        logic [NREQ-1:0] newb;
        logic [DW-1:0] prd;
        logic sle;
        int g, w, k;
        bit timed;
        pending = '0;
        req = '0;
        PREADY = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                // Pending requesters withdraw before being granted: nothing may start.
                pending = '0;
                req = '0;
                tick();
                tests++;
                if (grant !== '0 || PSELx !== 1'b0 || ack !== '0) begin
                    fails++;
                    $display("FAIL rnd_idle%0d: got grant=%b psel=%b", t, grant, PSELx);
                end
            end
            newb = 4'($urandom_range(0, 15)) & ~pending;
            if ((pending | newb) == '0) newb = 4'(1 << $urandom_range(0, NREQ - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (newb[i]) begin
                    m_addr[i] = $urandom; m_wdata[i] = $urandom; m_write[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW] = m_addr[i];
                    req_wdata[i*DW +: DW] = m_wdata[i];
                    req_write[i] = m_write[i];
                end
            end
            pending = pending | newb;
            req = pending;
            g = rr_pick(pending, mlast);
            l_addr = m_addr[g]; l_wdata = m_wdata[g]; l_write = m_write[g];
            tick();
            tests++;
            if (grant !== 4'(1 << g) || PSELx !== 1'b1 || PENABLE !== 1'b0 || PADDR !== l_addr ||
                PWDATA !== l_wdata || PWRITE !== l_write) begin
                fails++;
                $display("FAIL rnd_grant%0d: got grant=%b paddr=%h pwrite=%b, expected %b %h %b", t,
                         grant, PADDR, PWRITE, 4'(1 << g), l_addr, l_write);
            end
            req_addr[g*AW +: AW] = $urandom;
            req_wdata[g*DW +: DW] = $urandom;
            req_write[g] = ~l_write;
            if ($urandom_range(0, 3) == 0) begin
                pending[g] = 1'b0;
                req = pending;
            end
            tick();
            w = $urandom_range(0, 5);
            timed = (w >= TMO);
            k = timed ? TMO : w + 1;
            for (int i = 1; i <= k; i++) begin
                PREADY = (i > w);
                prd = $urandom;
                sle = 1'($urandom_range(0, 1));
                PRDATA = prd;
                PSLVERR = sle;
                tick();
                if (i < k) begin
                    tests++;
                    if (ack !== '0 || PENABLE !== 1'b1 || PADDR !== l_addr || PWDATA !== l_wdata) begin
                        fails++;
                        $display("FAIL rnd_wait%0d_%0d: got ack=%b pen=%b paddr=%h, expected 0 1 %h",
                                 t, i, ack, PENABLE, PADDR, l_addr);
                    end
                end else begin
                    if (!l_write) mrdata = timed ? '0 : prd;
                    tests++;
                    if (ack !== 4'(1 << g) || err !== (timed ? 1'b1 : sle) || rdata !== mrdata ||
                        {PSELx, PENABLE, grant} !== '0) begin
                        fails++;
                        $display("FAIL rnd_done%0d: got ack=%b err=%b rdata=%h, expected %b %b %h",
                                 t, ack, err, rdata, 4'(1 << g), timed ? 1'b1 : sle, mrdata);
                    end
                end
            end
            PREADY = 1'b0;
            PSLVERR = 1'b0;
            pending[g] = 1'b0;
            req = pending;
            mlast = g;
        end
        req = '0;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_read();
        test_write_wait();
        test_round_robin();
        test_priority_rotation();
        test_timeout();
        test_slave_error();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
